matrix_scan_bcm: RTL and testbench



---
 rtl/matrix_scan_bcm.sv | 246 ++++++++++++++++++++++++
 tb/tb_matrix_scan_bcm.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_bcm.sv
// matrix_scan_bcm: HUB75-style panel scanner with binary-code-modulated
// on-times. The next bitplane is shifted in while the current one is shown.
// All outputs are registered and follow the internal state by one cycle.
// Optional feature: define MATRIX_SCAN_GLOBAL_DIM_EN to add the global_dim
// input, which shortens every OE window to (W*global_dim)>>8 ticks.
module matrix_scan_bcm #(
    parameter int COLUMNS         = 64,
    parameter int COL_WIDTH       = 6,
    parameter int ROW_ADDR_WIDTH  = 4,
    parameter int BRIGHTNESS_BITS = 6,
    parameter int BASE_OE_TICKS   = 8,
    parameter int OE_CNT_WIDTH    = 12,
    parameter int BLANK_TICKS     = 2,
    parameter int LATCH_TICKS     = 1
) (
    input  logic                       clk_in,
    input  logic                       reset,
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
    input  logic [7:0]                 global_dim,
`endif
    output logic [COL_WIDTH-1:0]       column_address,
    output logic [ROW_ADDR_WIDTH-1:0]  row_address,
    output logic [ROW_ADDR_WIDTH-1:0]  row_address_active,
    output logic [BRIGHTNESS_BITS-1:0] brightness_mask,
    output logic                       clk_pixel_load,
    output logic                       clk_pixel,
    output logic                       row_latch,
    output logic                       output_enable,
    output logic                       frame_start
);

    localparam int PLANE_W  = (BRIGHTNESS_BITS > 1) ? $clog2(BRIGHTNESS_BITS) : 1;
    localparam int TICK_MAX = (BLANK_TICKS > LATCH_TICKS) ? BLANK_TICKS : LATCH_TICKS;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [COL_WIDTH-1:0] COL_LAST    = COL_WIDTH'(COLUMNS - 1);
    localparam logic [PLANE_W-1:0]   PLANE_LAST  = PLANE_W'(BRIGHTNESS_BITS - 1);
    localparam logic [TICK_W-1:0]    BLANK_LAST  = TICK_W'(BLANK_TICKS - 1);
    localparam logic [TICK_W-1:0]    LATCH_LAST  = TICK_W'(LATCH_TICKS - 1);

    typedef enum logic [2:0] {
        ST_SHIFT      = 3'd0,
        ST_WAIT_OE    = 3'd1,
        ST_BLANK_PRE  = 3'd2,
        ST_LATCH      = 3'd3,
        ST_BLANK_POST = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  phase_q, phase_d;
    logic [COL_WIDTH-1:0]        col_q, col_d;
    logic [TICK_W-1:0]           tick_q, tick_d;
    logic [OE_CNT_WIDTH-1:0]     oe_cnt_q, oe_cnt_d;
    logic [PLANE_W-1:0]          shift_plane_q, shift_plane_d;
    logic [PLANE_W-1:0]          disp_plane_q, disp_plane_d;
    logic [ROW_ADDR_WIDTH-1:0]   row_q, row_d;
    logic [ROW_ADDR_WIDTH-1:0]   row_active_q, row_active_d;
    logic [COL_WIDTH-1:0]        column_address_q, column_address_d;
    logic [BRIGHTNESS_BITS-1:0]  brightness_mask_q, brightness_mask_d;
    logic                        clk_pixel_load_q, clk_pixel_load_d;
    logic                        clk_pixel_q, clk_pixel_d;
    logic                        row_latch_q, row_latch_d;
    logic                        output_enable_q, output_enable_d;
    logic                        frame_start_q, frame_start_d;
    logic [OE_CNT_WIDTH-1:0]     win_s;

    // Window length for the plane that was just latched onto the panel.
    assign win_s = OE_CNT_WIDTH'(BASE_OE_TICKS) << disp_plane_q;

`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
    logic [OE_CNT_WIDTH+7:0]     dim_prod_s;
    logic [OE_CNT_WIDTH-1:0]     dim_on_s;
    logic [OE_CNT_WIDTH-1:0]     oe_off_q, oe_off_d;

    // OE stays on while the counter is above oe_off, i.e. the first
    // (W*global_dim)>>8 ticks of the window; the threshold is fixed at load.
    assign dim_prod_s = {8'd0, win_s} * {{OE_CNT_WIDTH{1'b0}}, global_dim};
    assign dim_on_s   = OE_CNT_WIDTH'(dim_prod_s >> 8);

    // Dimming threshold register, captured together with the window load.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            oe_off_q <= '0;
        end else begin
            oe_off_q <= oe_off_d;
        end
    end
`endif

    // Sequencer, counters and registered panel/fetch outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q           <= ST_SHIFT;
            phase_q           <= 2'd0;
            col_q             <= '0;
            tick_q            <= '0;
            oe_cnt_q          <= '0;
            shift_plane_q     <= '0;
            disp_plane_q      <= '0;
            row_q             <= '0;
            row_active_q      <= '0;
            column_address_q  <= '0;
            brightness_mask_q <= BRIGHTNESS_BITS'(1);
            clk_pixel_load_q  <= 1'b0;
            clk_pixel_q       <= 1'b0;
            row_latch_q       <= 1'b0;
            output_enable_q   <= 1'b0;
            frame_start_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            phase_q           <= phase_d;
            col_q             <= col_d;
            tick_q            <= tick_d;
            oe_cnt_q          <= oe_cnt_d;
            shift_plane_q     <= shift_plane_d;
            disp_plane_q      <= disp_plane_d;
            row_q             <= row_d;
            row_active_q      <= row_active_d;
            column_address_q  <= column_address_d;
            brightness_mask_q <= brightness_mask_d;
            clk_pixel_load_q  <= clk_pixel_load_d;
            clk_pixel_q       <= clk_pixel_d;
            row_latch_q       <= row_latch_d;
            output_enable_q   <= output_enable_d;
            frame_start_q     <= frame_start_d;
        end
    end

    // Next-state logic: shift/wait/blank/latch sequencing and OE window counter.
    always_comb begin
        state_d          = state_q;
        phase_d          = phase_q;
        col_d            = col_q;
        tick_d           = tick_q;
        oe_cnt_d         = (oe_cnt_q != '0) ? (oe_cnt_q - OE_CNT_WIDTH'(1)) : '0;
        shift_plane_d    = shift_plane_q;
        disp_plane_d     = disp_plane_q;
        row_d            = row_q;
        row_active_d     = row_active_q;
        column_address_d = column_address_q;
        frame_start_d    = 1'b0;
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
        oe_off_d         = oe_off_q;
`endif

        case (state_q)
            ST_SHIFT: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd0) begin
                    column_address_d = col_q;
                end else begin
                    column_address_d = column_address_q;
                end
                if (phase_q == 2'd3) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = ST_WAIT_OE;
                    end else begin
                        col_d = col_q + COL_WIDTH'(1);
                    end
                end else begin
                    col_d = col_q;
                end
            end
            ST_WAIT_OE: begin
                // Leave one cycle early so the counter hits zero exactly as
                // blanking starts; an already-empty window exits at once.
                if (oe_cnt_q <= OE_CNT_WIDTH'(1)) begin
                    state_d = ST_BLANK_PRE;
                    tick_d  = '0;
                end else begin
                    state_d = ST_WAIT_OE;
                end
            end
            ST_BLANK_PRE: begin
                if (tick_q == BLANK_LAST) begin
                    state_d = ST_LATCH;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_LATCH: begin
                if (tick_q == LATCH_LAST) begin
                    row_active_d  = row_q;
                    disp_plane_d  = shift_plane_q;
                    frame_start_d = (row_q == '0) && (shift_plane_q == '0);
                    state_d       = ST_BLANK_POST;
                    tick_d        = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_BLANK_POST: begin
                if (tick_q == BLANK_LAST) begin
                    oe_cnt_d = win_s;
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
                    oe_off_d = win_s - dim_on_s;
`endif
                    if (shift_plane_q == PLANE_LAST) begin
                        shift_plane_d = '0;
                        row_d         = row_q + ROW_ADDR_WIDTH'(1);
                    end else begin
                        shift_plane_d = shift_plane_q + PLANE_W'(1);
                    end
                    state_d = ST_SHIFT;
                    phase_d = 2'd0;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = ST_SHIFT;
                phase_d = 2'd0;
                col_d   = '0;
                tick_d  = '0;
            end
        endcase

        brightness_mask_d = BRIGHTNESS_BITS'(1) << shift_plane_d;
    end

    // Output decode from the current state; registered next cycle.
    always_comb begin
        clk_pixel_load_d = (state_q == ST_SHIFT) && (phase_q == 2'd0);
        clk_pixel_d      = (state_q == ST_SHIFT) && phase_q[1];
        row_latch_d      = (state_q == ST_LATCH);
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
        output_enable_d  = (oe_cnt_q > oe_off_q);
`else
        output_enable_d  = (oe_cnt_q != '0);
`endif
    end

    assign column_address     = column_address_q;
    assign row_address        = row_q;
    assign row_address_active = row_active_q;
    assign brightness_mask    = brightness_mask_q;
    assign clk_pixel_load     = clk_pixel_load_q;
    assign clk_pixel          = clk_pixel_q;
    assign row_latch          = row_latch_q;
    assign output_enable      = output_enable_q;
    assign frame_start        = frame_start_q;

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Testbench for matrix_scan_bcm: two small instances (fast window and
// stalling window) checked against a schedule model built from the scan rules.
module tb_matrix_scan_bcm;

    localparam int CA = 4, BASEA = 8;
    localparam int CB = 4, BASEB = 64;
    localparam int BT = 2, LT = 1;
    localparam int BBM = 2, ROWSM = 2;
    localparam int NS = 1400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] gdim = 8'd255;

    logic [1:0] a_col, b_col;
    logic [0:0] a_row, a_act, b_row, b_act;
    logic [1:0] a_mask, b_mask;
    logic a_load, a_pix, a_latch, a_oe, a_fs;
    logic b_load, b_pix, b_latch, b_oe, b_fs;

    int checks = 0;
    int errors = 0;

    int m_load [2][NS];
    int m_pix  [2][NS];
    int m_lat  [2][NS];
    int m_oe   [2][NS];
    int m_fs   [2][NS];
    int m_col  [2][NS];
    int m_mask [2][NS];
    int m_row  [2][NS];
    int m_act  [2][NS];

    always #5 clk = ~clk;

    matrix_scan_bcm #(.COLUMNS(CA), .COL_WIDTH(2), .ROW_ADDR_WIDTH(1), .BRIGHTNESS_BITS(2),
                      .BASE_OE_TICKS(BASEA), .OE_CNT_WIDTH(12), .BLANK_TICKS(BT), .LATCH_TICKS(LT))
    dut_a (
        .clk_in(clk), .reset(reset),
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
        .global_dim(gdim),
`endif
        .column_address(a_col), .row_address(a_row), .row_address_active(a_act),
        .brightness_mask(a_mask), .clk_pixel_load(a_load), .clk_pixel(a_pix),
        .row_latch(a_latch), .output_enable(a_oe), .frame_start(a_fs)
    );

    matrix_scan_bcm #(.COLUMNS(CB), .COL_WIDTH(2), .ROW_ADDR_WIDTH(1), .BRIGHTNESS_BITS(2),
                      .BASE_OE_TICKS(BASEB), .OE_CNT_WIDTH(12), .BLANK_TICKS(BT), .LATCH_TICKS(LT))
    dut_b (
        .clk_in(clk), .reset(reset),
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
        .global_dim(gdim),
`endif
        .column_address(b_col), .row_address(b_row), .row_address_active(b_act),
        .brightness_mask(b_mask), .clk_pixel_load(b_load), .clk_pixel(b_pix),
        .row_latch(b_latch), .output_enable(b_oe), .frame_start(b_fs)
    );

    // Number of OE-high ticks expected in a window of length w.
    function automatic int exp_on(input int w, input int dimv);
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
        return (w * dimv) >> 8;
`else
        return w + 0 * dimv;
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Schedule model: sample k shows the effect of cycle k after reset release.
    task automatic build_model(input int d, input int cols, input int base, input int dimv);
        int pos, s, w, on, plane, row, act, mask, col, tw, dplane, fs, lat;
        for (int t = 0; t < NS; t++) begin
            m_load[d][t] = 0; m_pix[d][t] = 0; m_lat[d][t] = 0; m_oe[d][t] = 0; m_fs[d][t] = 0;
        end
        pos = 0; s = 0; w = 0; plane = 0; row = 0; act = 0; mask = 1; col = 0; dplane = 0;
        while (pos < NS) begin
            for (int c = 0; c < cols; c++) begin
                for (int p = 0; p < 4; p++) begin
                    int t;
                    t = pos + 4 * c + p;
                    if (p == 0) col = c;
                    if (t < NS) begin
                        m_load[d][t] = (p == 0); m_pix[d][t] = (p >= 2);
                        m_col[d][t] = col; m_mask[d][t] = mask; m_row[d][t] = row; m_act[d][t] = act;
                    end
                end
            end
            pos = pos + 4 * cols;
            tw = (s + w - 1 > pos) ? (s + w - 1) : pos;
            for (int t = pos; t <= tw + 2 * BT + LT; t++) begin
                fs = 0;
                lat = (t > tw + BT) && (t <= tw + BT + LT);
                if (t == tw + BT + LT) begin
                    act = row; dplane = plane; fs = (row == 0 && plane == 0);
                end
                if (t == tw + 2 * BT + LT) begin
                    if (plane == BBM - 1) begin
                        plane = 0; row = (row + 1) % ROWSM;
                    end else begin
                        plane = plane + 1;
                    end
                    mask = 1 << plane;
                end
                if (t < NS) begin
                    m_lat[d][t] = lat; m_fs[d][t] = fs;
                    m_col[d][t] = col; m_mask[d][t] = mask; m_row[d][t] = row; m_act[d][t] = act;
                end
            end
            w = base << dplane;
            s = tw + 2 * BT + LT + 1;
            on = exp_on(w, dimv);
            for (int t = s; t < s + on; t++) begin
                if (t < NS) m_oe[d][t] = 1;
            end
            pos = s;
        end
    endtask

    task automatic test_reset();
        logic [10:0] got_a, got_b;
        do_reset();
        repeat ($urandom_range(3, 13)) @(negedge clk);
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        got_a = {a_load, a_pix, a_latch, a_oe, a_fs, a_col, a_mask, a_row, a_act};
        got_b = {b_load, b_pix, b_latch, b_oe, b_fs, b_col, b_mask, b_row, b_act};
        checks++;
        if (got_a !== 11'b00000_00_01_0_0) begin
            errors++; $display("FAIL reset_async_a got %b expected %b", got_a, 11'b00000_00_01_0_0);
        end
        checks++;
        if (got_b !== 11'b00000_00_01_0_0) begin
            errors++; $display("FAIL reset_async_b got %b expected %b", got_b, 11'b00000_00_01_0_0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({a_load, a_col} !== 3'b1_00) begin
            errors++; $display("FAIL first_load_a got load=%b col=%0d expected load=1 col=0", a_load, a_col);
        end
        checks++;
        if ({b_load, b_col} !== 3'b1_00) begin
            errors++; $display("FAIL first_load_b got load=%b col=%0d expected load=1 col=0", b_load, b_col);
        end
    endtask

    task automatic test_waveform(input int n);
        logic [10:0] got, exp;
        int fa, fb;
        fa = 0; fb = 0;
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
        gdim = 8'($urandom_range(0, 255));
`endif
        do_reset();
        build_model(0, CA, BASEA, int'(gdim));
        build_model(1, CB, BASEB, int'(gdim));
        for (int k = 0; k < n; k++) begin
            @(posedge clk); @(negedge clk);
            if (fa < 8) begin
                got = {a_load, a_pix, a_latch, a_oe, a_fs, a_col, a_mask, a_row, a_act};
                exp = {1'(m_load[0][k]), 1'(m_pix[0][k]), 1'(m_lat[0][k]), 1'(m_oe[0][k]), 1'(m_fs[0][k]),
                       2'(m_col[0][k]), 2'(m_mask[0][k]), 1'(m_row[0][k]), 1'(m_act[0][k])};
                checks++;
                if (got !== exp) begin
                    errors++; fa++;
                    $display("FAIL waveform_a sample %0d got %b expected %b (load pix lat oe fs col mask row act)", k, got, exp);
                end
            end
            if (fb < 8) begin
                got = {b_load, b_pix, b_latch, b_oe, b_fs, b_col, b_mask, b_row, b_act};
                exp = {1'(m_load[1][k]), 1'(m_pix[1][k]), 1'(m_lat[1][k]), 1'(m_oe[1][k]), 1'(m_fs[1][k]),
                       2'(m_col[1][k]), 2'(m_mask[1][k]), 1'(m_row[1][k]), 1'(m_act[1][k])};
                checks++;
                if (got !== exp) begin
                    errors++; fb++;
                    $display("FAIL waveform_b sample %0d got %b expected %b (load pix lat oe fs col mask row act)", k, got, exp);
                end
            end
        end
    endtask

    task automatic test_counts();
        int loads, pixr, prev_pix, prev_oe, oe_len, run, li, fs_cnt;
        logic [1:0] prev_mask, exp_mask;
        loads = 0; pixr = 0; prev_pix = 0; prev_oe = 0; oe_len = 0; run = 0; li = 0; fs_cnt = 0;
        prev_mask = 2'd1;
        gdim = 8'd255;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); @(negedge clk);
            if (a_mask !== prev_mask) begin
                exp_mask = (prev_mask == 2'd1) ? 2'd2 : 2'd1;
                checks++;
                if (loads != CA || pixr != CA || a_mask !== exp_mask) begin
                    errors++;
                    $display("FAIL plane_counts got loads=%0d pix=%0d mask=%b expected loads=%0d pix=%0d mask=%b",
                             loads, pixr, a_mask, CA, CA, exp_mask);
                end
                loads = 0; pixr = 0;
            end
            prev_mask = a_mask;
            if (a_load) loads++;
            if (a_pix && prev_pix == 0) pixr++;
            prev_pix = int'(a_pix);
            if (prev_oe == 1 && !a_oe) begin
                checks++;
                if (oe_len != exp_on(BASEA << (run % 2), int'(gdim))) begin
                    errors++;
                    $display("FAIL oe_width window %0d got %0d expected %0d", run, oe_len,
                             exp_on(BASEA << (run % 2), int'(gdim)));
                end
                run++;
            end
            oe_len = a_oe ? oe_len + 1 : 0;
            prev_oe = int'(a_oe);
            if (a_fs) fs_cnt++;
            if (a_latch) begin
                checks++;
                if (a_act !== 1'((li / 2) % 2) || a_fs !== (li % 4 == 0)) begin
                    errors++;
                    $display("FAIL latch_seq latch %0d got active=%0d fs=%b expected active=%0d fs=%0d",
                             li, a_act, a_fs, (li / 2) % 2, (li % 4 == 0));
                end
                li++;
            end
        end
        checks++;
        if (li < 8 || fs_cnt != (li + 3) / 4) begin
            errors++;
            $display("FAIL frame_count got latches=%0d frame_starts=%0d expected >=8 latches and %0d frame_starts",
                     li, fs_cnt, (li + 3) / 4);
        end
    endtask

    task automatic test_stall();
        int low_len, lat_in_gap, rises, prev_oe, viol, fs_cnt, wprev, exp_gap;
        low_len = 0; lat_in_gap = 0; rises = 0; prev_oe = 0; viol = 0; fs_cnt = 0;
        gdim = 8'd200;
        do_reset();
        for (int k = 0; k < 1300; k++) begin
            @(posedge clk); @(negedge clk);
            if ((b_latch && b_oe) || (b_latch && b_pix) || (a_latch && a_oe) || (a_latch && a_pix)) viol++;
            if (b_fs) fs_cnt++;
            if (b_oe && prev_oe == 0) begin
                if (rises > 0) begin
                    wprev = BASEB << ((rises - 1) % 2);
                    exp_gap = 2 * BT + LT + wprev - exp_on(wprev, int'(gdim));
                    checks++;
                    if (low_len != exp_gap || lat_in_gap != LT) begin
                        errors++;
                        $display("FAIL stall_gap rise %0d got low=%0d latch=%0d expected low=%0d latch=%0d",
                                 rises, low_len, lat_in_gap, exp_gap, LT);
                    end
                end
                rises++;
                low_len = 0; lat_in_gap = 0;
            end
            if (!b_oe) begin
                low_len++;
                if (b_latch) lat_in_gap++;
            end
            prev_oe = int'(b_oe);
        end
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL latch_overlap got %0d overlapping samples expected 0", viol);
        end
        checks++;
        if (fs_cnt < 3) begin
            errors++; $display("FAIL stall_frames got %0d frame_starts expected at least 3", fs_cnt);
        end
    endtask

`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
    task automatic test_global_dim();
        int oe_len, prev_oe, run, highs;
        oe_len = 0; prev_oe = 0; run = 0; highs = 0;
        gdim = 8'd128;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); @(negedge clk);
            if (prev_oe == 1 && !a_oe) begin
                checks++;
                if (oe_len != ((run % 2 == 0) ? 4 : 8)) begin
                    errors++;
                    $display("FAIL dim128_width window %0d got %0d expected %0d", run, oe_len, (run % 2 == 0) ? 4 : 8);
                end
                run++;
            end
            oe_len = a_oe ? oe_len + 1 : 0;
            prev_oe = int'(a_oe);
        end
        gdim = 8'd0;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); @(negedge clk);
            if (a_oe || b_oe) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++; $display("FAIL dim0_dark got %0d OE-high samples expected 0", highs);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_waveform(NS);
        test_waveform(NS);
        test_counts();
        test_stall();
`ifdef MATRIX_SCAN_GLOBAL_DIM_EN
        test_global_dim();
`endif
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
